// File: rtl/dmem_wt_cache.sv
// Direct-mapped, one-word-per-line, write-through, no-write-allocate data cache
// sitting between the CPU MEM/WB stages and a single-word backing memory.
module dmem_wt_cache #(
  parameter int IDX_BITS = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [31:0] mem_address,
  input  logic [3:0]  mem_byte_enable,
  input  logic [31:0] mem_wdata,
  input  logic        mem_stall,
  output logic        mem_resp,
  output logic        mem_ready,
  output logic [31:0] mem_rdata,
  output logic        pmem_read,
  output logic        pmem_write,
  output logic [31:0] pmem_address,
  output logic [3:0]  pmem_byte_enable,
  output logic [31:0] pmem_wdata,
  input  logic [31:0] pmem_rdata,
  input  logic        pmem_resp
);

  localparam int NLINES = 1 << IDX_BITS;
  localparam int TAG_W  = 30 - IDX_BITS;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_WRITE = 2'd2;

  logic [1:0]          state_q, state_d;
  logic                ack_q, ack_d;
  logic                ready_q, ready_d;
  logic [31:0]         rdata_q, rdata_d;
  logic [NLINES-1:0]   valid_q;
  logic [TAG_W-1:0]    tag_q  [NLINES];
  logic [31:0]         data_q [NLINES];

  logic [IDX_BITS-1:0] idx;
  logic [TAG_W-1:0]    tag;
  logic                hit;
  logic                req;
  logic                fill_en;
  logic                merge_en;
  logic [31:0]         merged;
  logic                unused_addr_bits;

  assign idx = mem_address[2+IDX_BITS-1:2];
  assign tag = mem_address[31:2+IDX_BITS];
  assign hit = valid_q[idx] && (tag_q[idx] == tag);
  assign req = (mem_read | mem_write) & ~mem_stall;
  assign unused_addr_bits = ^mem_address[1:0];

  always_comb begin
    merged = data_q[idx];
    for (int b = 0; b < 4; b++) begin
      if (mem_byte_enable[b]) merged[8*b +: 8] = mem_wdata[8*b +: 8];
    end
  end

  always_comb begin
    state_d  = state_q;
    ack_d    = ack_q;
    ready_d  = 1'b0;
    rdata_d  = rdata_q;
    mem_resp = 1'b0;
    fill_en  = 1'b0;
    merge_en = 1'b0;
    case (state_q)
      S_IDLE: begin
        mem_resp = 1'b1;
        // The store that just completed is still held by the pipeline this cycle.
        if (ack_q) begin
          ack_d = 1'b0;
        end else if (req && mem_write) begin
          mem_resp = 1'b0;
          state_d  = S_WRITE;
        end else if (req && mem_read) begin
          if (hit) begin
            ready_d = 1'b1;
            rdata_d = data_q[idx];
          end else begin
            mem_resp = 1'b0;
            state_d  = S_FETCH;
          end
        end
      end
      S_FETCH: begin
        if (pmem_resp) begin
          fill_en = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_WRITE: begin
        if (pmem_resp) begin
          merge_en = hit;
          ack_d    = 1'b1;
          state_d  = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      ack_q   <= 1'b0;
      ready_q <= 1'b0;
      rdata_q <= 32'h0;
      valid_q <= '0;
    end else begin
      state_q <= state_d;
      ack_q   <= ack_d;
      ready_q <= ready_d;
      rdata_q <= rdata_d;
      if (fill_en) valid_q[idx] <= 1'b1;
    end
  end

  // Tag/data storage needs no reset; the valid bits gate every use.
  always_ff @(posedge clk) begin
    if (fill_en) begin
      data_q[idx] <= pmem_rdata;
      tag_q[idx]  <= tag;
    end else if (merge_en) begin
      data_q[idx] <= merged;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && !mem_stall) assert (!(mem_read && mem_write));
  end

  assign mem_ready        = ready_q;
  assign mem_rdata        = rdata_q;
  assign pmem_read        = (state_q == S_FETCH);
  assign pmem_write       = (state_q == S_WRITE);
  assign pmem_address     = {mem_address[31:2], 2'b00};
  assign pmem_byte_enable = (state_q == S_WRITE) ? mem_byte_enable : 4'hF;
  assign pmem_wdata       = mem_wdata;

endmodule

// File: tb/tb_dmem_wt_cache.sv
// Directed bench for dmem_wt_cache: a latency-programmable backing memory model
// plus per-scenario tasks with hand-computed expectations.
module tb_dmem_wt_cache;

  logic        clk;
  logic        rst_n;
  logic        mem_read, mem_write, mem_stall;
  logic [31:0] mem_address, mem_wdata;
  logic [3:0]  mem_byte_enable;
  logic        mem_resp, mem_ready;
  logic [31:0] mem_rdata;
  logic        pmem_read, pmem_write;
  logic [31:0] pmem_address, pmem_wdata, pmem_rdata;
  logic [3:0]  pmem_byte_enable;
  logic        pmem_resp;

  int checks = 0;
  int errors = 0;

  int pmem_lat = 3;
  int rd_cnt = 0, wr_cnt = 0, both_cnt = 0;
  logic [31:0] last_rd_addr, last_wr_addr, last_wr_data;
  logic [3:0]  last_rd_be, last_wr_be;

  dmem_wt_cache #(.IDX_BITS(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
    .mem_byte_enable(mem_byte_enable), .mem_wdata(mem_wdata), .mem_stall(mem_stall),
    .mem_resp(mem_resp), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
    .pmem_byte_enable(pmem_byte_enable), .pmem_wdata(pmem_wdata),
    .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Backing memory: pmem_resp pulses after pmem_lat cycles of a held strobe.
  initial begin
    int cnt;
    cnt = 0;
    pmem_resp = 1'b0;
    forever begin
      @(negedge clk);
      if ((pmem_read || pmem_write) && !pmem_resp) begin
        cnt++;
        if (cnt >= pmem_lat) begin
          pmem_resp = 1'b1;
          cnt = 0;
        end
      end else begin
        pmem_resp = 1'b0;
        cnt = 0;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (pmem_read) begin
        rd_cnt++;
        last_rd_addr = pmem_address;
        last_rd_be   = pmem_byte_enable;
      end
      if (pmem_write) begin
        wr_cnt++;
        last_wr_addr = pmem_address;
        last_wr_be   = pmem_byte_enable;
        last_wr_data = pmem_wdata;
      end
      if (pmem_read && pmem_write) both_cnt++;
    end
  end

  task automatic do_read(input logic [31:0] addr, output int waits, output bit to,
                         output logic rdy, output logic [31:0] rd);
    waits = 0;
    to = 1'b0;
    @(posedge clk); #1;
    mem_read = 1'b1;
    mem_address = addr;
    forever begin
      @(negedge clk);
      if (mem_resp) break;
      waits++;
      if (waits > 60) begin
        to = 1'b1;
        break;
      end
    end
    @(posedge clk); #1;
    mem_read = 1'b0;
    @(negedge clk);
    rdy = mem_ready;
    rd  = mem_rdata;
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [3:0] be, input logic [31:0] wd,
                          output int waits, output bit to, output logic rdy);
    waits = 0;
    to = 1'b0;
    @(posedge clk); #1;
    mem_write = 1'b1;
    mem_address = addr;
    mem_byte_enable = be;
    mem_wdata = wd;
    forever begin
      @(negedge clk);
      if (mem_resp) break;
      waits++;
      if (waits > 60) begin
        to = 1'b1;
        break;
      end
    end
    @(posedge clk); #1;
    mem_write = 1'b0;
    @(negedge clk);
    rdy = mem_ready;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    mem_read = 0; mem_write = 0; mem_stall = 0;
    mem_address = 0; mem_wdata = 0; mem_byte_enable = 0;
    pmem_rdata = 0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (mem_ready !== 1'b0 || mem_rdata !== 32'h0) begin
      errors++;
      $display("FAIL reset_out: ready=%b rdata=%h required ready=0 rdata=0", mem_ready, mem_rdata);
    end
    checks++;
    if (pmem_read !== 1'b0 || pmem_write !== 1'b0 || mem_resp !== 1'b1) begin
      errors++;
      $display("FAIL reset_idle: pr=%b pw=%b resp=%b required 0 0 1", pmem_read, pmem_write, mem_resp);
    end
  endtask

  task automatic test_read_miss();
    int w; bit to; logic rdy; logic [31:0] rd;
    pmem_rdata = 32'hDEADBEEF;
    rd_cnt = 0;
    do_read(32'h100, w, to, rdy, rd);
    checks++;
    if (to || w !== 4) begin
      errors++;
      $display("FAIL miss_latency: resp-low cycles=%0d timeout=%0d required 4", w, to);
    end
    checks++;
    if (rd_cnt !== 3 || last_rd_addr !== 32'h100 || last_rd_be !== 4'hF) begin
      errors++;
      $display("FAIL miss_pmem: cycles=%0d addr=%h be=%h required 3 00000100 f", rd_cnt, last_rd_addr, last_rd_be);
    end
    checks++;
    if (rdy !== 1'b1 || rd !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL miss_data: ready=%b rdata=%h required 1 deadbeef", rdy, rd);
    end
  endtask

  task automatic test_read_hit();
    int w; bit to; logic rdy; logic [31:0] rd;
    pmem_rdata = 32'h0BAD0BAD;
    rd_cnt = 0;
    do_read(32'h100, w, to, rdy, rd);
    checks++;
    if (to || w !== 0 || rd_cnt !== 0) begin
      errors++;
      $display("FAIL hit_latency: waits=%0d pmem_reads=%0d required 0 0", w, rd_cnt);
    end
    checks++;
    if (rdy !== 1'b1 || rd !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL hit_data: ready=%b rdata=%h required 1 deadbeef", rdy, rd);
    end
    @(negedge clk);
    checks++;
    if (mem_ready !== 1'b0 || mem_rdata !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL idle_hold: ready=%b rdata=%h required 0 deadbeef", mem_ready, mem_rdata);
    end
  endtask

  task automatic test_stall();
    rd_cnt = 0;
    @(posedge clk); #1;
    mem_read = 1'b1; mem_address = 32'h180; mem_stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if (mem_resp !== 1'b1) begin
        errors++;
        $display("FAIL stall_resp: resp=%b required 1", mem_resp);
      end
    end
    @(posedge clk); #1;
    mem_read = 1'b0; mem_stall = 1'b0;
    @(negedge clk);
    checks++;
    if (mem_ready !== 1'b0 || rd_cnt !== 0) begin
      errors++;
      $display("FAIL stall_idle: ready=%b pmem_reads=%0d required 0 0", mem_ready, rd_cnt);
    end
  endtask

  task automatic test_write_hit();
    int w; bit to; logic rdy; logic [31:0] rd;
    wr_cnt = 0; rd_cnt = 0;
    do_write(32'h100, 4'h2, 32'h0000AA00, w, to, rdy);
    checks++;
    if (to || w !== 4 || wr_cnt !== 3) begin
      errors++;
      $display("FAIL write_latency: waits=%0d pmem_writes=%0d required 4 3", w, wr_cnt);
    end
    checks++;
    if (last_wr_addr !== 32'h100 || last_wr_be !== 4'h2 || last_wr_data !== 32'h0000AA00) begin
      errors++;
      $display("FAIL write_pmem: addr=%h be=%h data=%h required 00000100 2 0000aa00",
               last_wr_addr, last_wr_be, last_wr_data);
    end
    checks++;
    if (rdy !== 1'b0 || both_cnt !== 0) begin
      errors++;
      $display("FAIL write_ready: ready=%b both_strobes=%0d required 0 0", rdy, both_cnt);
    end
    do_read(32'h100, w, to, rdy, rd);
    checks++;
    if (to || w !== 0 || rd_cnt !== 0 || rd !== 32'hDEADAAEF || rdy !== 1'b1) begin
      errors++;
      $display("FAIL write_merge: waits=%0d reads=%0d ready=%b rdata=%h required 0 0 1 deadaaef",
               w, rd_cnt, rdy, rd);
    end
  endtask

  task automatic test_write_miss();
    int w; bit to; logic rdy; logic [31:0] rd;
    wr_cnt = 0; rd_cnt = 0;
    do_write(32'h200, 4'hF, 32'h12345678, w, to, rdy);
    checks++;
    if (to || w !== 4 || wr_cnt !== 3 || last_wr_be !== 4'hF) begin
      errors++;
      $display("FAIL wmiss_write: waits=%0d writes=%0d be=%h required 4 3 f", w, wr_cnt, last_wr_be);
    end
    pmem_rdata = 32'h12345678;
    do_read(32'h200, w, to, rdy, rd);
    checks++;
    if (to || w !== 4 || rd_cnt !== 3 || last_rd_addr !== 32'h200) begin
      errors++;
      $display("FAIL wmiss_no_alloc: waits=%0d reads=%0d addr=%h required 4 3 00000200",
               w, rd_cnt, last_rd_addr);
    end
    checks++;
    if (rdy !== 1'b1 || rd !== 32'h12345678) begin
      errors++;
      $display("FAIL wmiss_data: ready=%b rdata=%h required 1 12345678", rdy, rd);
    end
  endtask

  task automatic test_conflict();
    int w; bit to; logic rdy; logic [31:0] rd;
    rd_cnt = 0;
    pmem_rdata = 32'h11112222;
    do_read(32'h140, w, to, rdy, rd);
    checks++;
    if (to || rd_cnt !== 3 || rd !== 32'h11112222) begin
      errors++;
      $display("FAIL conflict_140: reads=%0d rdata=%h required 3 11112222", rd_cnt, rd);
    end
    rd_cnt = 0;
    pmem_rdata = 32'hDEADAAEF;
    do_read(32'h100, w, to, rdy, rd);
    checks++;
    if (to || w !== 4 || rd_cnt !== 3 || rd !== 32'hDEADAAEF) begin
      errors++;
      $display("FAIL conflict_100: waits=%0d reads=%0d rdata=%h required 4 3 deadaaef", w, rd_cnt, rd);
    end
    rd_cnt = 0;
    pmem_rdata = 32'h0;
    do_read(32'h140, w, to, rdy, rd);
    checks++;
    if (to || rd_cnt !== 3 || rd !== 32'h0) begin
      errors++;
      $display("FAIL conflict_evict: reads=%0d rdata=%h required 3 00000000", rd_cnt, rd);
    end
  endtask

  task automatic test_reset_mid_fetch();
    int w; bit to; logic rdy; logic [31:0] rd;
    pmem_lat = 20;
    @(posedge clk); #1;
    mem_read = 1'b1; mem_address = 32'h108;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (pmem_read !== 1'b1) begin
      errors++;
      $display("FAIL fetch_active: pmem_read=%b required 1", pmem_read);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (pmem_read !== 1'b0 || mem_ready !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: pmem_read=%b ready=%b required 0 0", pmem_read, mem_ready);
    end
    @(posedge clk); #1;
    mem_read = 1'b0;
    rst_n = 1'b1;
    pmem_lat = 3;
    rd_cnt = 0;
    pmem_rdata = 32'hDEADAAEF;
    do_read(32'h100, w, to, rdy, rd);
    checks++;
    if (to || w !== 4 || rd_cnt !== 3 || rd !== 32'hDEADAAEF) begin
      errors++;
      $display("FAIL post_reset_miss: waits=%0d reads=%0d rdata=%h required 4 3 deadaaef", w, rd_cnt, rd);
    end
    checks++;
    if (both_cnt !== 0) begin
      errors++;
      $display("FAIL strobe_overlap: cycles=%0d required 0", both_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_read_miss();
    test_read_hit();
    test_stall();
    test_write_hit();
    test_write_miss();
    test_conflict();
    test_reset_mid_fetch();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
